// File: rtl/counter_cmd_if.sv
// Command handshake bundle between a command source and the counter command sequencer.
interface counter_cmd_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid_in;
  logic             cmd_ready_out;
  logic [1:0]       cmd_op_in;
  logic [WIDTH-1:0] cmd_arg_in;

  modport master (
    output cmd_valid_in,
    output cmd_op_in,
    output cmd_arg_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in,
    input  cmd_op_in,
    input  cmd_arg_in,
    output cmd_ready_out
  );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// Expands LOAD/UP/DOWN/NOP commands into registered, cycle-exact control strobes
// for the downstream 8-bit up/down counter.
//
// state | meaning
// IDLE  | waiting for a command; ready when not aborting
// SET   | one cycle of set_ctrl_out with the load value presented
// COUNT | en_ctrl_out high for rem more cycles
// SKIP  | one empty cycle closing a NOP or zero-length count
module counter_cmd_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  counter_cmd_if.slave     cmd,
  input  logic             abort_in,
  output logic             en_ctrl_out,
  output logic             set_ctrl_out,
  output logic             up_ctrl_out,
  output logic [WIDTH-1:0] counter_data_out,
  output logic             busy_out,
  output logic             done_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SET   = 2'b01,
    ST_COUNT = 2'b10,
    ST_SKIP  = 2'b11
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic             en_nxt, set_nxt, up_nxt, done_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             cmd_ready;
  logic             accept;

  assign cmd_ready         = rst_in && (state == ST_IDLE) && !abort_in;
  assign cmd.cmd_ready_out = cmd_ready;
  assign accept            = cmd.cmd_valid_in && cmd_ready;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    en_nxt    = 1'b0;
    set_nxt   = 1'b0;
    done_nxt  = 1'b0;
    up_nxt    = up_ctrl_out;
    data_nxt  = counter_data_out;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd.cmd_op_in)
            OP_LOAD: begin
              state_nxt = ST_SET;
              set_nxt   = 1'b1;
              done_nxt  = 1'b1;
              data_nxt  = cmd.cmd_arg_in;
            end
            OP_UP, OP_DOWN: begin
              if (cmd.cmd_arg_in != '0) begin
                state_nxt = ST_COUNT;
                rem_nxt   = cmd.cmd_arg_in;
                en_nxt    = 1'b1;
                done_nxt  = (cmd.cmd_arg_in == WIDTH'(1));
                up_nxt    = (cmd.cmd_op_in == OP_UP);
              end else begin
                state_nxt = ST_SKIP;
                done_nxt  = 1'b1;
              end
            end
            default: begin
              state_nxt = ST_SKIP;
              done_nxt  = 1'b1;
            end
          endcase
        end
      end
      ST_SET, ST_SKIP: begin
        state_nxt = ST_IDLE;
      end
      ST_COUNT: begin
        rem_nxt = rem - WIDTH'(1);
        if (rem == WIDTH'(1)) begin
          state_nxt = ST_IDLE;
        end else begin
          en_nxt   = 1'b1;
          done_nxt = (rem == WIDTH'(2));
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort discards whatever the command still had queued, without a done pulse.
    if (abort_in && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      rem_nxt   = '0;
      en_nxt    = 1'b0;
      set_nxt   = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= ST_IDLE;
      rem              <= '0;
      en_ctrl_out      <= 1'b0;
      set_ctrl_out     <= 1'b0;
      up_ctrl_out      <= 1'b0;
      counter_data_out <= '0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      state            <= state_nxt;
      rem              <= rem_nxt;
      en_ctrl_out      <= en_nxt;
      set_ctrl_out     <= set_nxt;
      up_ctrl_out      <= up_nxt;
      counter_data_out <= data_nxt;
      busy_out         <= (state_nxt != ST_IDLE);
      done_out         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer: transaction-level expectation queue
// compared every cycle, plus a downstream counter and literal scenario checks.
module tb_counter_cmd_sequencer;
  localparam int WIDTH = 8;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             abort_in = 1'b0;
  logic             en, set, up, busy, done;
  logic [WIDTH-1:0] data;

  counter_cmd_if #(.WIDTH(WIDTH)) cmd_if ();

  counter_cmd_sequencer #(.WIDTH(WIDTH)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .cmd              (cmd_if.slave),
    .abort_in         (abort_in),
    .en_ctrl_out      (en),
    .set_ctrl_out     (set),
    .up_ctrl_out      (up),
    .counter_data_out (data),
    .busy_out         (busy),
    .done_out         (done)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream 8-bit up/down counter driven by the sequencer outputs.
  logic [7:0] cnt;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cnt <= 8'h00;
    else if (set) cnt <= data;
    else if (en) cnt <= up ? cnt + 8'h01 : cnt - 8'h01;
  end

  // Expected outputs per cycle, queued at acceptance time.
  typedef struct packed {
    logic busy;
    logic done;
    logic en;
    logic set;
  } exp_t;

  function automatic exp_t mk(input logic b, input logic d, input logic e, input logic s);
    exp_t r;
    r.busy = b; r.done = d; r.en = e; r.set = s;
    return r;
  endfunction

  exp_t       cur = '0;
  exp_t       q[$];
  logic       m_up = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_acc;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      q.delete();
      cur    = '0;
      m_up   = 1'b0;
      m_data = 8'h00;
    end else begin
      m_acc = cmd_if.cmd_valid_in && !cur.busy && !abort_in;
      if (cur.busy && abort_in) begin
        q.delete();
        cur = '0;
      end else begin
        if (m_acc) begin
          case (cmd_if.cmd_op_in)
            2'b01: begin
              q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
              m_data = cmd_if.cmd_arg_in;
            end
            2'b10, 2'b11: begin
              if (cmd_if.cmd_arg_in == 8'd0) begin
                q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
              end else begin
                for (int i = 1; i <= int'(cmd_if.cmd_arg_in); i++)
                  q.push_back(mk(1'b1, i == int'(cmd_if.cmd_arg_in), 1'b1, 1'b0));
                m_up = (cmd_if.cmd_op_in == 2'b10);
              end
            end
            default: q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
          endcase
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = '0;
      end
    end
  end

  logic chk_on = 1'b0;
  always @(negedge clk_in) begin
    if (chk_on) begin
      chk("cyc_en",    en,   cur.en);
      chk("cyc_set",   set,  cur.set);
      chk("cyc_done",  done, cur.done);
      chk("cyc_busy",  busy, cur.busy);
      chk("cyc_up",    up,   m_up);
      chk("cyc_data",  data, m_data);
      chk("cyc_ready", cmd_if.cmd_ready_out, rst_in && !cur.busy && !abort_in);
    end
  end

  int en_total = 0, done_total = 0, set_total = 0;
  always @(negedge clk_in) begin
    en_total   += int'(en);
    done_total += int'(done);
    set_total  += int'(set);
  end

  logic       c_en[16], c_set[16], c_done[16], c_busy[16], c_up[16], c_rdy[16];
  logic [7:0] c_cnt[16];

  task automatic capture(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      @(negedge clk_in);
      c_en[i] = en; c_set[i] = set; c_done[i] = done; c_busy[i] = busy;
      c_up[i] = up; c_rdy[i] = cmd_if.cmd_ready_out; c_cnt[i] = cnt;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] arg, input logic keep);
    logic r;
    int tries;
    tries = 0;
    cmd_if.cmd_valid_in = 1'b1;
    cmd_if.cmd_op_in    = op;
    cmd_if.cmd_arg_in   = arg;
    do begin
      @(negedge clk_in);
      r = cmd_if.cmd_ready_out;
      @(posedge clk_in);
      #1;
      tries++;
    end while (!r && tries < 50);
    chk("accept", r, 1'b1);
    if (!keep) cmd_if.cmd_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk_in);
      t++;
    end while (busy && t < 400);
    chk("idle_timeout", busy, 1'b0);
    tick(1);
  endtask

  int e0, d0, s0, n_en, n_ovf;

  initial begin
    cmd_if.cmd_valid_in = 1'b0;
    cmd_if.cmd_op_in    = 2'b00;
    cmd_if.cmd_arg_in   = 8'h00;
    #2 rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_en", en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", cmd_if.cmd_ready_out, 1'b0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    chk_on = 1'b1;
    tick(2);

    // Reset in the third enable cycle of UP 10
    send(2'b10, 8'd10, 1'b0);
    tick(2);
    #2 rst_in = 1'b0;
    #1;
    chk("midrst_en", en, 1'b0);
    chk("midrst_up", up, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", cmd_if.cmd_ready_out, 1'b0);
    tick(2);
    rst_in = 1'b1;
    e0 = en_total;
    tick(6);
    @(negedge clk_in);
    chk("postrst_ready", cmd_if.cmd_ready_out, 1'b1);
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_no_en", en_total - e0, 0);
    tick(1);

    // LOAD 0xA5
    send(2'b01, 8'hA5, 1'b0);
    capture(0, 2);
    chk("load_set0", c_set[0], 1'b1);
    chk("load_done0", c_done[0], 1'b1);
    chk("load_en0", c_en[0], 1'b0);
    chk("load_set1", c_set[1], 1'b0);
    chk("load_cnt", c_cnt[1], 8'hA5);
    tick(1);

    // LOAD 0xFD then UP 3 across the counter wrap
    send(2'b01, 8'hFD, 1'b0);
    wait_idle();
    send(2'b10, 8'd3, 1'b0);
    capture(0, 4);
    n_en = 0; n_ovf = 0;
    for (int i = 0; i < 4; i++) begin
      n_en  += int'(c_en[i]);
      n_ovf += int'(c_cnt[i] == 8'hFF);
    end
    chk("up3_en_cycles", n_en, 3);
    chk("up3_dir", c_up[0], 1'b1);
    chk("up3_cnt1", c_cnt[1], 8'hFE);
    chk("up3_cnt2", c_cnt[2], 8'hFF);
    chk("up3_cnt3", c_cnt[3], 8'h00);
    chk("up3_ovf_cycles", n_ovf, 1);
    chk("up3_done_last", c_done[2], 1'b1);
    chk("up3_done_early", c_done[1], 1'b0);
    tick(1);

    // NOP then DOWN 0
    e0 = en_total; s0 = set_total;
    send(2'b00, 8'h00, 1'b0);
    capture(0, 2);
    chk("nop_busy", c_busy[0], 1'b1);
    chk("nop_done", c_done[0], 1'b1);
    chk("nop_end", c_busy[1], 1'b0);
    tick(1);
    send(2'b11, 8'd0, 1'b0);
    capture(0, 2);
    chk("down0_busy", c_busy[0], 1'b1);
    chk("down0_done", c_done[0], 1'b1);
    chk("down0_up_kept", c_up[1], 1'b1);
    chk("skip_no_en", en_total - e0, 0);
    chk("skip_no_set", set_total - s0, 0);
    tick(1);

    // DOWN 200 aborted during the fifth enable cycle
    send(2'b11, 8'd200, 1'b0);
    e0 = en_total; d0 = done_total;
    tick(4);
    abort_in = 1'b1;
    tick(1);
    abort_in = 1'b0;
    @(negedge clk_in);
    chk("abort_en", en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_en_cycles", en_total - e0, 5);
    chk("abort_no_done", done_total - d0, 0);
    chk("abort_cnt", cnt, 8'hFB);
    tick(1);

    // Abort in IDLE blocks a valid command
    e0 = en_total;
    abort_in = 1'b1;
    cmd_if.cmd_valid_in = 1'b1;
    cmd_if.cmd_op_in = 2'b10;
    cmd_if.cmd_arg_in = 8'd5;
    tick(2);
    abort_in = 1'b0;
    cmd_if.cmd_valid_in = 1'b0;
    @(negedge clk_in);
    chk("idle_abort_busy", busy, 1'b0);
    chk("idle_abort_no_en", en_total - e0, 0);
    tick(1);

    // Back-to-back UP 2 then DOWN 2 with valid held
    send(2'b10, 8'd2, 1'b1);
    cmd_if.cmd_op_in = 2'b11;
    cmd_if.cmd_arg_in = 8'd2;
    capture(0, 3);
    @(posedge clk_in);
    #1 cmd_if.cmd_valid_in = 1'b0;
    capture(3, 3);
    n_en = 0;
    for (int i = 0; i < 6; i++) n_en += int'(c_en[i]);
    chk("b2b_rdy_done", c_rdy[1], 1'b0);
    chk("b2b_done1", c_done[1], 1'b1);
    chk("b2b_rdy_gap", c_rdy[2], 1'b1);
    chk("b2b_en_gap", c_en[2], 1'b0);
    chk("b2b_up_gap", c_up[2], 1'b1);
    chk("b2b_up_second", c_up[3], 1'b0);
    chk("b2b_en_second", c_en[3], 1'b1);
    chk("b2b_done2", c_done[4], 1'b1);
    chk("b2b_en_cycles", n_en, 4);
    chk("b2b_cnt_mid", c_cnt[2], 8'hFD);
    chk("b2b_cnt_net", c_cnt[5], 8'hFB);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
